// File: rtl/nasti_err_slave_if.sv
// NASTI (AXI4) bus bundle seen by the default error responder.
// Only the fields the responder uses are carried; data/strobe/user on W are never inspected.
interface nasti_err_slave_if #(
    parameter int ID_WIDTH   = 1,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int USER_WIDTH = 1
);
    logic [ID_WIDTH-1:0]   aw_id;
    logic [ADDR_WIDTH-1:0] aw_addr;
    logic [7:0]            aw_len;
    logic                  aw_valid;
    logic                  aw_ready;

    logic                  w_last;
    logic                  w_valid;
    logic                  w_ready;

    logic [ID_WIDTH-1:0]   b_id;
    logic [1:0]            b_resp;
    logic [USER_WIDTH-1:0] b_user;
    logic                  b_valid;
    logic                  b_ready;

    logic [ID_WIDTH-1:0]   ar_id;
    logic [ADDR_WIDTH-1:0] ar_addr;
    logic [7:0]            ar_len;
    logic                  ar_valid;
    logic                  ar_ready;

    logic [ID_WIDTH-1:0]   r_id;
    logic [DATA_WIDTH-1:0] r_data;
    logic [1:0]            r_resp;
    logic                  r_last;
    logic [USER_WIDTH-1:0] r_user;
    logic                  r_valid;
    logic                  r_ready;

    modport master (
        output aw_id, aw_addr, aw_len, aw_valid,
        input  aw_ready,
        output w_last, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );

    modport slave (
        input  aw_id, aw_addr, aw_len, aw_valid,
        output aw_ready,
        input  w_last, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );
endinterface

// File: rtl/nasti_err_slave.sv
// Default NASTI error responder: completes every accepted write and read with RESP (DECERR).
// Optional error statistics (counters, last address) are enabled by defining NASTI_ERR_SLAVE_COUNT_EN.
module nasti_err_slave #(
    parameter int         ID_WIDTH   = 1,
    parameter int         ADDR_WIDTH = 8,
    parameter int         DATA_WIDTH = 8,
    parameter int         USER_WIDTH = 1,
    parameter logic [1:0] RESP       = 2'b11
) (
    input  logic                  clk,
    input  logic                  rst,
    nasti_err_slave_if.slave      bus
`ifdef NASTI_ERR_SLAVE_COUNT_EN
    ,
    output logic [15:0]           wr_err_cnt,
    output logic [15:0]           rd_err_cnt,
    output logic [ADDR_WIDTH-1:0] err_addr,
    output logic                  err_is_write
`endif
);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

    wstate_t               wstate, wstate_nxt;
    rstate_t               rstate, rstate_nxt;

    logic [ID_WIDTH-1:0]   wid_p0;
    logic [ID_WIDTH-1:0]   rid_p0;
    logic [7:0]            rcnt_p0;

    logic                  aw_ready_c, w_ready_c, b_valid_c;
    logic                  ar_ready_c, r_valid_c;
    logic                  aw_ready_g, w_ready_g, b_valid_g;
    logic                  ar_ready_g, r_valid_g;
    logic                  aw_hs, ar_hs, r_hs;

`ifdef NASTI_ERR_SLAVE_COUNT_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction
`endif

    // Write path: accept AW, swallow beats until w_last, then return one B.
    always_comb begin
        wstate_nxt = wstate;
        aw_ready_c = 1'b0;
        w_ready_c  = 1'b0;
        b_valid_c  = 1'b0;
        case (wstate)
            W_IDLE: begin
                aw_ready_c = 1'b1;
                if (bus.aw_valid) wstate_nxt = W_DATA;
            end
            W_DATA: begin
                w_ready_c = 1'b1;
                if (bus.w_valid && bus.w_last) wstate_nxt = W_RESP;
            end
            W_RESP: begin
                b_valid_c = 1'b1;
                if (bus.b_ready) wstate_nxt = W_IDLE;
            end
            default: wstate_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) wstate <= W_IDLE;
        else     wstate <= wstate_nxt;
    end

    // Read path: accept AR, stream ar_len+1 zero beats, last flagged when the count hits zero.
    always_comb begin
        rstate_nxt = rstate;
        ar_ready_c = 1'b0;
        r_valid_c  = 1'b0;
        case (rstate)
            R_IDLE: begin
                ar_ready_c = 1'b1;
                if (bus.ar_valid) rstate_nxt = R_DATA;
            end
            R_DATA: begin
                r_valid_c = 1'b1;
                if (bus.r_ready && (rcnt_p0 == 8'd0)) rstate_nxt = R_IDLE;
            end
            default: rstate_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) rstate <= R_IDLE;
        else     rstate <= rstate_nxt;
    end

    // Handshake qualifiers are masked by reset so nothing can complete while it is held.
    assign aw_ready_g = aw_ready_c & ~rst;
    assign w_ready_g  = w_ready_c  & ~rst;
    assign b_valid_g  = b_valid_c  & ~rst;
    assign ar_ready_g = ar_ready_c & ~rst;
    assign r_valid_g  = r_valid_c  & ~rst;

    assign aw_hs = bus.aw_valid & aw_ready_g;
    assign ar_hs = bus.ar_valid & ar_ready_g;
    assign r_hs  = r_valid_g & bus.r_ready;

    // Payload registers carry no reset; they are only observed behind a valid.
    always_ff @(posedge clk) begin
        if (aw_hs) wid_p0 <= bus.aw_id;
        if (ar_hs) begin
            rid_p0  <= bus.ar_id;
            rcnt_p0 <= bus.ar_len;
        end else if (r_hs && (rcnt_p0 != 8'd0)) begin
            rcnt_p0 <= rcnt_p0 - 8'd1;
        end
    end

    assign bus.aw_ready = aw_ready_g;
    assign bus.w_ready  = w_ready_g;
    assign bus.b_valid  = b_valid_g;
    assign bus.b_id     = b_valid_g ? wid_p0 : '0;
    assign bus.b_resp   = b_valid_g ? RESP : 2'b00;
    assign bus.b_user   = '0;

    assign bus.ar_ready = ar_ready_g;
    assign bus.r_valid  = r_valid_g;
    assign bus.r_id     = r_valid_g ? rid_p0 : '0;
    assign bus.r_data   = '0;
    assign bus.r_resp   = r_valid_g ? RESP : 2'b00;
    assign bus.r_last   = r_valid_g & (rcnt_p0 == 8'd0);
    assign bus.r_user   = '0;

`ifdef NASTI_ERR_SLAVE_COUNT_EN
    // AW wins the address capture when both paths accept in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_err_cnt   <= 16'd0;
            rd_err_cnt   <= 16'd0;
            err_addr     <= '0;
            err_is_write <= 1'b0;
        end else begin
            if (aw_hs) wr_err_cnt <= sat_inc(wr_err_cnt);
            if (ar_hs) rd_err_cnt <= sat_inc(rd_err_cnt);
            if (aw_hs) begin
                err_addr     <= bus.aw_addr;
                err_is_write <= 1'b1;
            end else if (ar_hs) begin
                err_addr     <= bus.ar_addr;
                err_is_write <= 1'b0;
            end
        end
    end

    logic unused_sigs;
    assign unused_sigs = ^{bus.aw_len};
`else
    logic unused_sigs;
    assign unused_sigs = ^{bus.aw_len, bus.aw_addr, bus.ar_addr};
`endif

endmodule

// File: tb/tb_nasti_err_slave.sv
// Bench for nasti_err_slave: directed scenarios plus random traffic against a transaction-level model.
module tb_nasti_err_slave;
    localparam int ID_W = 2;
    localparam int AD_W = 8;
    localparam int DT_W = 8;
    localparam int US_W = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    nasti_err_slave_if #(.ID_WIDTH(ID_W), .ADDR_WIDTH(AD_W), .DATA_WIDTH(DT_W), .USER_WIDTH(US_W)) bus ();

`ifdef NASTI_ERR_SLAVE_COUNT_EN
    logic [15:0]     wr_err_cnt, rd_err_cnt;
    logic [AD_W-1:0] err_addr;
    logic            err_is_write;
`endif

    nasti_err_slave #(.ID_WIDTH(ID_W), .ADDR_WIDTH(AD_W), .DATA_WIDTH(DT_W), .USER_WIDTH(US_W), .RESP(2'b11)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef NASTI_ERR_SLAVE_COUNT_EN
        ,
        .wr_err_cnt  (wr_err_cnt),
        .rd_err_cnt  (rd_err_cnt),
        .err_addr    (err_addr),
        .err_is_write(err_is_write)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Transaction-level model: a write is outstanding from AW acceptance until B completes;
    // a read is a number of beats still owed.
    bit              m_w_busy, m_w_done;
    logic [ID_W-1:0] m_w_id, m_r_id;
    int              m_r_left;
    int              m_wr_cnt, m_rd_cnt;
    logic [AD_W-1:0] m_err_addr;
    bit              m_err_is_write;
    int              b_seen, r_seen, rlast_seen;

    always @(negedge clk) begin
        bit e_awr, e_wr, e_bv, e_arr, e_rv;
        bit hs_aw, hs_w_last, hs_b, hs_ar, hs_r;
        if (rst) begin
            check("rst_aw_ready", 64'(bus.aw_ready), 64'(0));
            check("rst_w_ready",  64'(bus.w_ready),  64'(0));
            check("rst_b_valid",  64'(bus.b_valid),  64'(0));
            check("rst_ar_ready", 64'(bus.ar_ready), 64'(0));
            check("rst_r_valid",  64'(bus.r_valid),  64'(0));
            m_w_busy = 0; m_w_done = 0; m_r_left = 0;
            m_wr_cnt = 0; m_rd_cnt = 0; m_err_addr = '0; m_err_is_write = 0;
        end else begin
            e_awr = !m_w_busy;
            e_wr  = m_w_busy && !m_w_done;
            e_bv  = m_w_busy && m_w_done;
            e_arr = (m_r_left == 0);
            e_rv  = (m_r_left != 0);
            check("aw_ready", 64'(bus.aw_ready), 64'(e_awr));
            check("w_ready",  64'(bus.w_ready),  64'(e_wr));
            check("b_valid",  64'(bus.b_valid),  64'(e_bv));
            check("b_id",     64'(bus.b_id),     e_bv ? 64'(m_w_id) : 64'(0));
            check("b_resp",   64'(bus.b_resp),   e_bv ? 64'(3) : 64'(0));
            check("b_user",   64'(bus.b_user),   64'(0));
            check("ar_ready", 64'(bus.ar_ready), 64'(e_arr));
            check("r_valid",  64'(bus.r_valid),  64'(e_rv));
            check("r_id",     64'(bus.r_id),     e_rv ? 64'(m_r_id) : 64'(0));
            check("r_data",   64'(bus.r_data),   64'(0));
            check("r_resp",   64'(bus.r_resp),   e_rv ? 64'(3) : 64'(0));
            check("r_last",   64'(bus.r_last),   64'(m_r_left == 1));
            check("r_user",   64'(bus.r_user),   64'(0));
`ifdef NASTI_ERR_SLAVE_COUNT_EN
            check("wr_err_cnt",   64'(wr_err_cnt),   64'(m_wr_cnt));
            check("rd_err_cnt",   64'(rd_err_cnt),   64'(m_rd_cnt));
            check("err_addr",     64'(err_addr),     64'(m_err_addr));
            check("err_is_write", 64'(err_is_write), 64'(m_err_is_write));
`endif
            if (bus.b_valid && bus.b_ready) b_seen++;
            if (bus.r_valid && bus.r_ready) r_seen++;
            if (bus.r_valid && bus.r_ready && bus.r_last) rlast_seen++;

            hs_aw     = bus.aw_valid && e_awr;
            hs_w_last = e_wr && bus.w_valid && bus.w_last;
            hs_b      = e_bv && bus.b_ready;
            hs_ar     = bus.ar_valid && e_arr;
            hs_r      = e_rv && bus.r_ready;
            if (hs_w_last) m_w_done = 1;
            if (hs_b) begin m_w_busy = 0; m_w_done = 0; end
            if (hs_aw) begin
                m_w_busy = 1; m_w_done = 0; m_w_id = bus.aw_id;
                if (m_wr_cnt < 65535) m_wr_cnt++;
            end
            if (hs_r) m_r_left--;
            if (hs_ar) begin
                m_r_left = int'(bus.ar_len) + 1; m_r_id = bus.ar_id;
                if (m_rd_cnt < 65535) m_rd_cnt++;
                m_err_addr = bus.ar_addr; m_err_is_write = 0;
            end
            if (hs_aw) begin m_err_addr = bus.aw_addr; m_err_is_write = 1; end
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_inputs();
        bus.aw_valid = 0; bus.aw_id = '0; bus.aw_addr = '0; bus.aw_len = '0;
        bus.w_valid = 0; bus.w_last = 0; bus.b_ready = 0;
        bus.ar_valid = 0; bus.ar_id = '0; bus.ar_addr = '0; bus.ar_len = '0;
        bus.r_ready = 0;
    endtask

    task automatic do_reset();
        rst = 1; cyc(2); rst = 0; cyc(1);
    endtask

    initial begin
        int b0, r0, l0;
        idle_inputs();
        rst = 1;
        cyc(3);
        rst = 0;
        cyc(1);

        // Write burst: AW id=1 len=3, four beats, B with id 1.
        b0 = b_seen;
        bus.aw_valid = 1; bus.aw_id = 2'd1; bus.aw_len = 8'd3; bus.aw_addr = 8'h5A;
        cyc(1);
        bus.aw_valid = 0; bus.w_valid = 1; bus.b_ready = 1;
        for (int i = 0; i < 4; i++) begin
            bus.w_last = (i == 3);
            cyc(1);
        end
        bus.w_valid = 0; bus.w_last = 0;
        cyc(4);
        check("wr_burst_b_count", 64'(b_seen - b0), 64'(1));
        idle_inputs();

        // Single-beat read.
        r0 = r_seen; l0 = rlast_seen;
        bus.ar_valid = 1; bus.ar_id = 2'd0; bus.ar_len = 8'd0; bus.ar_addr = 8'h33;
        cyc(1);
        bus.ar_valid = 0; bus.r_ready = 1;
        cyc(3);
        check("rd1_beats", 64'(r_seen - r0), 64'(1));
        check("rd1_lasts", 64'(rlast_seen - l0), 64'(1));
        idle_inputs();

        // 256-beat read with r_ready toggling.
        r0 = r_seen; l0 = rlast_seen;
        bus.ar_valid = 1; bus.ar_id = 2'd2; bus.ar_len = 8'd255;
        cyc(1);
        bus.ar_valid = 0;
        for (int i = 0; i < 600; i++) begin
            bus.r_ready = ~bus.r_ready;
            cyc(1);
        end
        check("rd256_beats", 64'(r_seen - r0), 64'(256));
        check("rd256_lasts", 64'(rlast_seen - l0), 64'(1));
        idle_inputs();

        // Simultaneous AW and AR, responses back-pressured for 5 cycles.
        do_reset();
        bus.aw_valid = 1; bus.aw_id = 2'd3; bus.aw_addr = 8'hA7; bus.aw_len = 8'd0;
        bus.ar_valid = 1; bus.ar_id = 2'd1; bus.ar_addr = 8'h4C; bus.ar_len = 8'd1;
        cyc(1);
        bus.aw_valid = 0; bus.ar_valid = 0;
        bus.w_valid = 1; bus.w_last = 1;
        cyc(1);
        bus.w_valid = 0; bus.w_last = 0;
        cyc(5);
`ifdef NASTI_ERR_SLAVE_COUNT_EN
        check("both_wr_cnt", 64'(wr_err_cnt), 64'(1));
        check("both_rd_cnt", 64'(rd_err_cnt), 64'(1));
        check("both_addr",   64'(err_addr),   64'(8'hA7));
`endif
        check("both_b_held", 64'(bus.b_valid), 64'(1));
        check("both_r_held", 64'(bus.r_valid), 64'(1));
        bus.b_ready = 1; bus.r_ready = 1;
        cyc(4);
        idle_inputs();

        // Reset during the second beat of an 8-beat read.
        r0 = r_seen;
        bus.ar_valid = 1; bus.ar_id = 2'd2; bus.ar_len = 8'd7;
        cyc(1);
        bus.ar_valid = 0; bus.r_ready = 1;
        cyc(1);
        rst = 1;
        cyc(1);
        rst = 0;
        cyc(6);
        check("rst_abort_beats", 64'(r_seen - r0), 64'(1));
        idle_inputs();

        // W presented before AW must not be accepted.
        bus.w_valid = 1; bus.w_last = 1; bus.b_ready = 1;
        cyc(4);
        bus.aw_valid = 1; bus.aw_id = 2'd2;
        cyc(1);
        bus.aw_valid = 0;
        cyc(3);
        idle_inputs();

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            bus.aw_valid = ($urandom_range(0, 3) == 0);
            bus.aw_id    = ID_W'($urandom);
            bus.aw_addr  = AD_W'($urandom);
            bus.aw_len   = 8'($urandom);
            bus.w_valid  = $urandom_range(0, 1);
            bus.w_last   = ($urandom_range(0, 2) == 0);
            bus.b_ready  = $urandom_range(0, 1);
            bus.ar_valid = ($urandom_range(0, 3) == 0);
            bus.ar_id    = ID_W'($urandom);
            bus.ar_addr  = AD_W'($urandom);
            bus.ar_len   = 8'($urandom_range(0, 9));
            bus.r_ready  = ($urandom_range(0, 3) != 0);
            rst          = ($urandom_range(0, 299) == 0);
            cyc(1);
        end
        rst = 0;
        idle_inputs();
        cyc(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/nasti_err_slave.md
# nasti_err_slave

Default error responder for a NASTI (AXI4) crossbar. Sits directly downstream of the address demux on the port that receives unmapped transactions: the demux falls back to port 0 on no address match, and that port connects here. It completes every write and read it accepts with a decode-error response, so a stray access never hangs the interconnect. The read and write paths are independent and each handles one outstanding transaction at a time.

## Interface
Parameters:
- ID_WIDTH, 1, transaction ID width
- ADDR_WIDTH, 8, address width
- DATA_WIDTH, 8, data width
- USER_WIDTH, 1, user field width (must be > 0)
- RESP, 2'b11, response code returned (DECERR)

Ports:
- clk  input  1  clock; all logic on rising edge
- rst  input  1  reset; synchronous, active-high
- aw_id, aw_addr, aw_len  input  ID_WIDTH, ADDR_WIDTH, 8  write address; other AW fields ignored
- aw_valid / aw_ready  input / output  1  AW handshake
- w_last, w_valid  input  1  write data; w_data/w_strb/w_user ignored
- w_ready  output  1  W handshake
- b_id, b_resp, b_user  output  ID_WIDTH, 2, USER_WIDTH  write response
- b_valid / b_ready  output / input  1  B handshake
- ar_id, ar_addr, ar_len  input  ID_WIDTH, ADDR_WIDTH, 8  read address
- ar_valid / ar_ready  input / output  1  AR handshake
- r_id, r_data, r_resp, r_last, r_user  output  ID_WIDTH, DATA_WIDTH, 2, 1, USER_WIDTH  read data
- r_valid / r_ready  output / input  1  R handshake

## Operation
- Write FSM states: W_IDLE, W_DATA, W_RESP.
  - W_IDLE: aw_ready=1. On aw_valid&&aw_ready, register aw_id and go to W_DATA.
  - W_DATA: w_ready=1. Discard beats. On w_valid&&w_ready&&w_last, go to W_RESP. The beat count is not checked against aw_len; only w_last ends the burst.
  - W_RESP: b_valid=1, b_id=registered ID, b_resp=RESP, b_user=0. On b_ready, go to W_IDLE.
- W beats that arrive before AW wait: w_ready=0 outside W_DATA.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: ar_ready=1. On handshake, register ar_id and set the 8-bit beat counter to ar_len.
  - R_DATA: r_valid=1, r_data=0, r_resp=RESP, r_user=0, r_id=registered ID, r_last=(cnt==0).
  - Each r_valid&&r_ready decrements cnt. A handshake with r_last set goes to R_IDLE.
  - ar_len=255 gives 256 beats; the counter never wraps below 0.
- AW and AR handshakes may fire in the same cycle; the two paths do not interact.

## Timing
- While rst=1 and in the first cycle after release, the FSMs hold in W_IDLE and R_IDLE.
- Every ready and valid output is gated by !rst, so all are 0 during reset.
- From the first cycle after reset: aw_ready=1, ar_ready=1; all other outputs 0.
- Latencies:
  - AW handshake in cycle N → w_ready=1 in N+1.
  - w_last handshake in N → b_valid=1 in N+1.
  - AR handshake in N → first r_valid in N+1.
- Throughput:
  - R beats are one per cycle while r_ready=1.
  - The next AW or AR is accepted no earlier than the cycle after B or the last R completes.
- A valid output, once asserted, holds its payload until the handshake completes (AXI rule).
- rst asserted mid-transaction aborts it: next cycle both FSMs are idle and all valid outputs are 0.

## Configuration
- NASTI_ERR_SLAVE_COUNT_EN defined adds these outputs:
  - wr_err_cnt[15:0]: increments on each AW handshake, saturates at 16'hFFFF.
  - rd_err_cnt[15:0]: increments on each AR handshake, saturates at 16'hFFFF.
  - err_addr[ADDR_WIDTH-1:0]: captures the address of the latest AW or AR handshake. If both fire in the same cycle, it takes the AW address.
  - err_is_write[0]: 1 when err_addr was captured from AW.
  - All four reset to 0.
- Undefined: these ports and registers do not exist; the rest of the block is unchanged.

## Test plan
- AW id=1 len=3, then 4 W beats with last on the 4th, b_ready=1 → exactly one B: id=1, resp=2'b11, one cycle after the last W.
- AR id=0 len=0 with r_ready=1 → one R beat: last=1, data=0, resp=2'b11; ar_ready high again in the next cycle.
- AR len=255 with r_ready toggling 1/0 → exactly 256 beats, r_last only on the 256th, payload stable while stalled.
- AW and AR in the same cycle, with b_ready and r_ready low for 5 cycles → both valids hold, aw_ready=ar_ready=0; with the macro, wr_err_cnt=rd_err_cnt=1 and err_addr=AW address.
- rst pulsed for 1 cycle during beat 2 of an AR len=7 → r_valid=0 the next cycle, ar_ready=1, no further beats.
- W valid presented before AW → w_ready stays 0 until the cycle after the AW handshake.
